// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared definitions for the pipeline sequencing controller.
// Holds the stall vector width and encodings, the sequencing FSM state
// encoding and the reset level used by pipe_ctrl and stall_watchdog.
// Optional feature macro used by the top: PIPE_CTRL_TRAP_EN.

package pipe_ctrl_pkg;

    // One hold bit per pipeline register: bit0 pc ... bit4 mem_wb.
    localparam int STALL_W = 5;

    localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
    localparam logic [STALL_W-1:0] STALL_IF   = 5'b00011;
    localparam logic [STALL_W-1:0] STALL_ID   = 5'b00111;
    localparam logic [STALL_W-1:0] STALL_EX   = 5'b01111;
    localparam logic [STALL_W-1:0] STALL_MEM  = 5'b11111;

    // Reset is active high.
    localparam logic RST_ENABLE = 1'b1;

    // RUN: normal, HOLD: redirect captured while fetch waits,
    // REDIR: redirect and flush being issued this cycle.
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HOLD  = 2'd1,
        ST_REDIR = 2'd2
    } pipe_state_e;

    // The furthest stage that requests a stall freezes itself and
    // everything upstream of it.
    function automatic logic [STALL_W-1:0] stall_vector(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [STALL_W-1:0] vec;
        vec = STALL_NONE;
        if (req_mem) begin
            vec = STALL_MEM;
        end else if (req_ex) begin
            vec = STALL_EX;
        end else if (req_id) begin
            vec = STALL_ID;
        end else if (req_if) begin
            vec = STALL_IF;
        end
        return vec;
    endfunction

endpackage

// File: rtl/pipe_ctrl_stall_watchdog.sv
// stall_watchdog: counts consecutive cycles with any stall request and
// flags a stuck pipeline once the count saturates at STALL_TIMEOUT.

module stall_watchdog
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic stall_any_i,
    output logic timeout_o
);

    localparam int CNT_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STALL_TIMEOUT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Count stalled cycles, hold at the limit, restart on any free cycle.
    always_comb begin
        count_d = '0;
        if (stall_any_i) begin
            if (count_q == LIMIT) begin
                count_d = count_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign timeout_o = (count_q == LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline sequencing controller for the five-stage core.
// Merges stall requests into the stall vector, turns execute-stage branches
// into a one-cycle redirect plus flush (held while fetch is stalled), and
// runs a stall watchdog.
// Optional feature: define PIPE_CTRL_TRAP_EN to add trap_req_i/trap_addr_i.

module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int STALL_TIMEOUT = 255,
    parameter int ADDR_W        = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if_i,
    input  logic              stallreq_id_i,
    input  logic              stallreq_ex_i,
    input  logic              stallreq_mem_i,
    input  logic              ex_branch_flag_i,
    input  logic [ADDR_W-1:0] ex_branch_addr_i,
`ifdef PIPE_CTRL_TRAP_EN
    input  logic              trap_req_i,
    input  logic [ADDR_W-1:0] trap_addr_i,
`endif
    output logic [STALL_W-1:0] stalled_o,
    output logic              redirect_o,
    output logic [ADDR_W-1:0] redirect_addr_o,
    output logic              flush_o,
    output logic              stall_timeout_o
);

    pipe_state_e       state_q;
    pipe_state_e       state_d;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              trap_req;
    logic [ADDR_W-1:0] trap_addr;
    logic              branch_ok;

`ifdef PIPE_CTRL_TRAP_EN
    assign trap_req  = trap_req_i;
    assign trap_addr = trap_addr_i;
`else
    assign trap_req  = 1'b0;
    assign trap_addr = '0;
`endif

    // A branch in execute is only trustworthy when execute and memory are
    // both moving; otherwise it will be presented again later.
    assign branch_ok = ex_branch_flag_i & ~stallreq_ex_i & ~stallreq_mem_i;

    // Next-state and redirect-target selection.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_RUN: begin
                if (trap_req) begin
                    addr_d  = trap_addr;
                    state_d = stallreq_if_i ? ST_HOLD : ST_REDIR;
                end else if (branch_ok) begin
                    addr_d  = ex_branch_addr_i;
                    state_d = stallreq_if_i ? ST_HOLD : ST_REDIR;
                end
            end
            ST_HOLD: begin
                if (trap_req) begin
                    addr_d = trap_addr;
                end
                if (!stallreq_if_i) begin
                    state_d = ST_REDIR;
                end
            end
            ST_REDIR: begin
                if (trap_req) begin
                    addr_d  = trap_addr;
                    state_d = ST_REDIR;
                end else begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // State and latched target registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst == RST_ENABLE) begin
            state_q <= ST_RUN;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign stalled_o = (rst == RST_ENABLE) ? STALL_MEM
                     : stall_vector(stallreq_if_i, stallreq_id_i,
                                    stallreq_ex_i, stallreq_mem_i);

    assign redirect_o      = (state_q == ST_REDIR);
    assign flush_o         = (state_q == ST_REDIR);
    assign redirect_addr_o = addr_q;

    stall_watchdog #(
        .STALL_TIMEOUT (STALL_TIMEOUT)
    ) u_watchdog (
        .clk         (clk),
        .rst         (rst),
        .stall_any_i (stallreq_if_i | stallreq_id_i | stallreq_ex_i | stallreq_mem_i),
        .timeout_o   (stall_timeout_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: self-checking bench for pipe_ctrl with STALL_TIMEOUT = 4.
// Trap scenarios are included when PIPE_CTRL_TRAP_EN is defined.

module tb_pipe_ctrl;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stallreq_if  = 1'b0;
    logic        stallreq_id  = 1'b0;
    logic        stallreq_ex  = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic        branch_flag  = 1'b0;
    logic [31:0] branch_addr  = 32'h0;
`ifdef PIPE_CTRL_TRAP_EN
    logic        trap_req     = 1'b0;
    logic [31:0] trap_addr    = 32'h0;
`endif
    logic [4:0]  stalled;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        flush;
    logic        stall_timeout;

    int checks = 0;
    int fails  = 0;
    logic [31:0] last_addr;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .STALL_TIMEOUT (TMO),
        .ADDR_W        (32)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .stallreq_if_i    (stallreq_if),
        .stallreq_id_i    (stallreq_id),
        .stallreq_ex_i    (stallreq_ex),
        .stallreq_mem_i   (stallreq_mem),
        .ex_branch_flag_i (branch_flag),
        .ex_branch_addr_i (branch_addr),
`ifdef PIPE_CTRL_TRAP_EN
        .trap_req_i       (trap_req),
        .trap_addr_i      (trap_addr),
`endif
        .stalled_o        (stalled),
        .redirect_o       (redirect),
        .redirect_addr_o  (redirect_addr),
        .flush_o          (flush),
        .stall_timeout_o  (stall_timeout)
    );

    // Shared comparison helper; every comparison steps the counters here.
    task automatic expectEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an owed redirect, a redirect being issued this
    // cycle, the target, and the length of the current stall run.
    bit          m_issue = 1'b0;
    bit          m_owed  = 1'b0;
    logic [31:0] m_addr  = 32'h0;
    int          m_run   = 0;

    // The furthest requesting stage holds itself and every earlier stage.
    function automatic logic [4:0] modelStall();
        int far;
        far = -1;
        if (stallreq_if)  far = 1;
        if (stallreq_id)  far = 2;
        if (stallreq_ex)  far = 3;
        if (stallreq_mem) far = 4;
        if (rst) return 5'b11111;
        if (far < 0) return 5'b00000;
        return 5'((1 << (far + 1)) - 1);
    endfunction

    // Advance the model one clock (or clear it on reset).
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_issue = 1'b0;
            m_owed  = 1'b0;
            m_addr  = 32'h0;
            m_run   = 0;
        end else begin
            if (stallreq_if || stallreq_id || stallreq_ex || stallreq_mem) begin
                if (m_run < 1000) m_run = m_run + 1;
            end else begin
                m_run = 0;
            end
            if (m_issue) begin
                m_issue = 1'b0;
`ifdef PIPE_CTRL_TRAP_EN
                if (trap_req) begin
                    m_addr  = trap_addr;
                    m_issue = 1'b1;
                end
`endif
            end else if (m_owed) begin
`ifdef PIPE_CTRL_TRAP_EN
                if (trap_req) m_addr = trap_addr;
`endif
                if (!stallreq_if) begin
                    m_owed  = 1'b0;
                    m_issue = 1'b1;
                end
            end else begin
                bit          take;
                logic [31:0] tgt;
                take = 1'b0;
                tgt  = 32'h0;
                if (branch_flag && !stallreq_ex && !stallreq_mem) begin
                    take = 1'b1;
                    tgt  = branch_addr;
                end
`ifdef PIPE_CTRL_TRAP_EN
                if (trap_req) begin
                    take = 1'b1;
                    tgt  = trap_addr;
                end
`endif
                if (take) begin
                    m_addr = tgt;
                    if (stallreq_if) m_owed = 1'b1;
                    else             m_issue = 1'b1;
                end
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        expectEq("model_stalled",  {27'h0, stalled},       {27'h0, modelStall()});
        expectEq("model_redirect", {31'h0, redirect},      {31'h0, m_issue});
        expectEq("model_flush",    {31'h0, flush},         {31'h0, m_issue});
        expectEq("model_addr",     redirect_addr,          m_addr);
        expectEq("model_timeout",  {31'h0, stall_timeout}, {31'h0, (m_run >= TMO)});
    end

    // Drive one cycle of inputs shortly after the rising edge.
    task automatic applyStimulus(input logic s_if, input logic s_id, input logic s_ex,
                                 input logic s_mem, input logic br, input logic [31:0] badr);
        @(posedge clk);
        #2;
        stallreq_if  = s_if;
        stallreq_id  = s_id;
        stallreq_ex  = s_ex;
        stallreq_mem = s_mem;
        branch_flag  = br;
        branch_addr  = badr;
`ifdef PIPE_CTRL_TRAP_EN
        trap_req     = 1'b0;
        trap_addr    = 32'h0;
`endif
    endtask

    // Hand-computed expectations for the current cycle; exp_to < 0 skips the watchdog.
    task automatic checkOutput(input string name, input logic [4:0] exp_st, input logic exp_rd,
                               input logic [31:0] exp_addr, input int exp_to);
        @(negedge clk);
        expectEq({name, "_stalled"},  {27'h0, stalled},  {27'h0, exp_st});
        expectEq({name, "_redirect"}, {31'h0, redirect}, {31'h0, exp_rd});
        expectEq({name, "_flush"},    {31'h0, flush},    {31'h0, exp_rd});
        expectEq({name, "_addr"},     redirect_addr,     exp_addr);
        if (exp_to >= 0) begin
            expectEq({name, "_timeout"}, {31'h0, stall_timeout}, 32'(exp_to));
        end
    endtask

    // Directed scenario sequence.
    initial begin
        #1 rst = 1'b1;
        checkOutput("reset", 5'b11111, 1'b0, 32'h0, 0);
        @(posedge clk); #2 rst = 1'b0;
        checkOutput("idle0", 5'b00000, 1'b0, 32'h0, 0);

        // Load-use stall for three cycles.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 1, 0, 0, 0, 32'h0);
            checkOutput("id_stall", 5'b00111, 1'b0, 32'h0, 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("id_done", 5'b00000, 1'b0, 32'h0, 0);

        // Plain taken branch.
        applyStimulus(0, 0, 0, 0, 1, 32'h0000_0100);
        checkOutput("br_accept", 5'b00000, 1'b0, 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("br_redirect", 5'b00000, 1'b1, 32'h100, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("br_after", 5'b00000, 1'b0, 32'h100, 0);

        // Branch while fetch waits four cycles; wrong-path branch ignored.
        applyStimulus(1, 0, 0, 0, 1, 32'h200);
        checkOutput("hold_accept", 5'b00011, 1'b0, 32'h100, 0);
        applyStimulus(1, 0, 0, 0, 1, 32'h300);
        checkOutput("hold_1", 5'b00011, 1'b0, 32'h200, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        checkOutput("hold_2", 5'b00011, 1'b0, 32'h200, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        checkOutput("hold_3", 5'b00011, 1'b0, 32'h200, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("hold_4", 5'b00000, 1'b0, 32'h200, 1);
        applyStimulus(0, 0, 0, 0, 1, 32'h400);
        checkOutput("hold_redirect", 5'b00000, 1'b1, 32'h200, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("redir_drop", 5'b00000, 1'b0, 32'h200, 0);

        // Branch behind a data-bus wait is deferred.
        applyStimulus(0, 0, 0, 1, 1, 32'h500);
        checkOutput("mem_1", 5'b11111, 1'b0, 32'h200, 0);
        applyStimulus(0, 0, 0, 1, 1, 32'h500);
        checkOutput("mem_2", 5'b11111, 1'b0, 32'h200, 0);
        applyStimulus(0, 0, 0, 0, 1, 32'h500);
        checkOutput("mem_accept", 5'b00000, 1'b0, 32'h200, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("mem_redirect", 5'b00000, 1'b1, 32'h500, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("mem_after", 5'b00000, 1'b0, 32'h500, 0);

        // Watchdog: execute stalls six cycles.
        for (int i = 1; i <= 6; i++) begin
            applyStimulus(0, 0, 1, 0, 0, 32'h0);
            checkOutput("ex_wd", 5'b01111, 1'b0, 32'h500, (i >= 5) ? 1 : 0);
        end
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("wd_release", 5'b00000, 1'b0, 32'h500, 1);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("wd_clear", 5'b00000, 1'b0, 32'h500, 0);
        last_addr = 32'h500;

`ifdef PIPE_CTRL_TRAP_EN
        // Trap beats a simultaneous branch, even under an execute stall.
        applyStimulus(0, 0, 1, 0, 1, 32'h200);
        trap_req  = 1'b1;
        trap_addr = 32'h80;
        checkOutput("trap_accept", 5'b01111, 1'b0, 32'h500, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("trap_redirect", 5'b00000, 1'b1, 32'h80, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        checkOutput("trap_after", 5'b00000, 1'b0, 32'h80, 0);
        last_addr = 32'h80;
`endif

        // Reset in the middle of HOLD discards the pending redirect.
        applyStimulus(1, 0, 0, 0, 1, 32'h600);
        checkOutput("rst_accept", 5'b00011, 1'b0, last_addr, 0);
        applyStimulus(1, 0, 0, 0, 0, 32'h0);
        rst = 1'b1;
        checkOutput("rst_hold", 5'b11111, 1'b0, 32'h0, 0);
        applyStimulus(0, 0, 0, 0, 0, 32'h0);
        rst = 1'b0;
        checkOutput("rst_release", 5'b00000, 1'b0, 32'h0, 0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, 0, 0, 32'h0);
            checkOutput("rst_quiet", 5'b00000, 1'b0, 32'h0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Safety bound so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL sim_timeout: got no completion, expected completion before 200000");
        $fatal(1, "[TB] simulation time limit reached");
    end

endmodule
